// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder family.
package adder_pkg;

  // Widest operand the adder family is intended to be built with.
  localparam int unsigned ADDER_MAX_WIDTH = 32;

  // Width used when an instance does not override WIDTH.
  localparam int unsigned ADDER_DEFAULT_WIDTH = 2;

  // Result bundle captured by the output register.
  typedef struct packed {
    logic                       valid;
    logic                       cout;
    logic [ADDER_MAX_WIDTH-1:0] sum;
    logic [ADDER_MAX_WIDTH-1:0] carry;
  } adder_res_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full-adder cell built from two half adders and an OR.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // First stage adds the operand bits.
  half_adder u_ha_lo (
    .x(x),
    .y(y),
    .s(s1),
    .c(c1)
  );

  // Second stage folds in the carry from the previous bit.
  half_adder u_ha_hi (
    .x(s1),
    .y(ci),
    .s(s),
    .c(c2)
  );

  // At most one of the two half-adder carries can be set, so OR merges them.
  always_comb begin
    co = c1 | c2;
  end

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  // Sum is the XOR and carry is the AND of the two inputs.
  always_comb begin
    s = x ^ y;
    c = x & y;
  end

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one clock after in_valid.
module full_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] carry
);

  // Operands are forced to zero when not valid so unknowns never reach the chain.
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic             cin_g;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic [WIDTH-1:0] carry_d,     carry_q;

  // Qualify the operands with in_valid.
  always_comb begin
    a_g   = in_valid ? a   : '0;
    b_g   = in_valid ? b   : '0;
    cin_g = in_valid ? cin : 1'b0;
  end

  // Ripple chain: each stage keeps its own carry wires so the chain is not one self-referencing
  // vector.
  for (genvar g = 0; g < WIDTH; g++) begin : gen_bit
    logic ci;
    logic co;

    if (g == 0) begin : gen_lsb
      assign ci = cin_g;
    end else begin : gen_upper
      assign ci = gen_bit[g-1].co;
    end

    fa_cell u_cell (
      .x (a_g[g]),
      .y (b_g[g]),
      .ci(ci),
      .s (sum_c[g]),
      .co(co)
    );

    assign carry_c[g] = co;
  end

  // Next state: load a new result on in_valid, otherwise hold the last one.
  always_comb begin
    out_valid_d = in_valid;
    sum_d       = sum_q;
    cout_d      = cout_q;
    carry_d     = carry_q;
    if (in_valid) begin
      sum_d   = sum_c;
      cout_d  = carry_c[WIDTH-1];
      carry_d = carry_c;
    end
  end

  // Output register with asynchronous clear; a reset drops any result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      carry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      carry_q     <= carry_d;
    end
  end

  // Drive the ports straight from the register.
  always_comb begin
    out_valid = out_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    carry     = carry_q;
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=2 and WIDTH=8.
module tb_full_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic [7:0] carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   mon_en = 1'b0;

  logic       in_valid2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       out_valid2;
  logic [1:0] sum2, carry2;
  logic       cout2;

  logic       in_valid8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       out_valid8;
  logic [7:0] sum8, carry8;
  logic       cout8;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q2[$];
  exp_t q8[$];
  exp_t hold2, hold8;
  logic exp_ov2, exp_ov8;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .a        (a2),
    .b        (b2),
    .cin      (cin2),
    .out_valid(out_valid2),
    .sum      (sum2),
    .cout     (cout2),
    .carry    (carry2)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .out_valid(out_valid8),
    .sum      (sum8),
    .cout     (cout8),
    .carry    (carry8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference: carry[i] is bit i+1 of the sum of the low i+1 bits.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    exp_t e;
    int   mask, full, m, t;
    e.sum   = '0;
    e.cout  = 1'b0;
    e.carry = '0;
    mask = (1 << w) - 1;
    full = (int'(a) & mask) + (int'(b) & mask) + int'(ci);
    e.sum  = 8'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
    for (int i = 0; i < w; i++) begin
      m = (1 << (i + 1)) - 1;
      t = (int'(a) & m) + (int'(b) & m) + int'(ci);
      e.carry[i] = ((t >> (i + 1)) & 1) != 0;
    end
    return e;
  endfunction

  // Expected out_valid: in_valid seen at the last edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ov2 <= 1'b0;
      exp_ov8 <= 1'b0;
    end else begin
      exp_ov2 <= in_valid2;
      exp_ov8 <= in_valid8;
    end
  end

  // Reset discards anything in flight and zeroes the held result.
  always @(negedge rst_n) begin
    q2.delete();
    q8.delete();
    hold2 = '{sum: 8'h0, cout: 1'b0, carry: 8'h0};
    hold8 = '{sum: 8'h0, cout: 1'b0, carry: 8'h0};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("ov2", 32'(out_valid2), 32'(exp_ov2));
      if (out_valid2) begin
        if (q2.size() == 0) check("q2_underflow", 32'(out_valid2), 32'h0);
        else hold2 = q2.pop_front();
      end
      check("sum2", 32'(sum2), 32'(hold2.sum));
      check("cout2", 32'(cout2), 32'(hold2.cout));
      check("carry2", 32'(carry2), 32'(hold2.carry));

      check("ov8", 32'(out_valid8), 32'(exp_ov8));
      if (out_valid8) begin
        if (q8.size() == 0) check("q8_underflow", 32'(out_valid8), 32'h0);
        else hold8 = q8.pop_front();
      end
      check("sum8", 32'(sum8), 32'(hold8.sum));
      check("cout8", 32'(cout8), 32'(hold8.cout));
      check("carry8", 32'(carry8), 32'(hold8.carry));
    end
  end

  // One cycle of stimulus to one DUT; the other DUT idles with random operands.
  task automatic drive(input bit sel8, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    @(posedge clk);
    #1;
    if (sel8) begin
      in_valid8 = v;  a8 = a;  b8 = b;  cin8 = ci;
      in_valid2 = 1'b0;  a2 = 2'($urandom);  b2 = 2'($urandom);  cin2 = 1'($urandom);
      if (v) q8.push_back(model(8, a, b, ci));
    end else begin
      in_valid2 = v;  a2 = a[1:0];  b2 = b[1:0];  cin2 = ci;
      in_valid8 = 1'b0;  a8 = 8'($urandom);  b8 = 8'($urandom);  cin8 = 1'($urandom);
      if (v) q2.push_back(model(2, {6'h0, a[1:0]}, {6'h0, b[1:0]}, ci));
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    hold2 = '{sum: 8'h0, cout: 1'b0, carry: 8'h0};
    hold8 = '{sum: 8'h0, cout: 1'b0, carry: 8'h0};

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("rst_sum2", 32'(sum2), 32'h0);
    check("rst_cout2", 32'(cout2), 32'h0);
    check("rst_ov2", 32'(out_valid2), 32'h0);
    check("rst_sum8", 32'(sum8), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Exhaustive with cin=0, then cin=1, back to back.
    for (int ci = 0; ci < 2; ci++)
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i >> 2), 8'(i & 3), 1'(ci));
    idle();

    // Hold: single pulse then five idle cycles with random operands.
    drive(1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
    repeat (5) idle();

    // Reset between edges while a result of 3 is on the outputs.
    drive(1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_sum2", 32'(sum2), 32'h3);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_sum2", 32'(sum2), 32'h0);
    check("mid_rst_cout2", 32'(cout2), 32'h0);
    check("mid_rst_ov2", 32'(out_valid2), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, 1'b1, 8'd2, 8'd1, 1'b0);
    idle();

    // Streaming: 16 consecutive random ops.
    for (int i = 0; i < 16; i++)
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle();

    // WIDTH=8 boundaries plus a few random ops.
    drive(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    drive(1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3) idle();

    @(negedge clk);
    #1;
    check("q2_drained", 32'(q2.size()), 32'h0);
    check("q8_drained", 32'(q8.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
